// File: rtl/reg_bus_pkg.sv
// Shared sizes and FSM state type for the register-bus read sequencer.
package reg_bus_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/reg_bus_reader_oe_decoder.sv
// 5-to-32 one-hot output-enable decoder; index 0 is never driven onto the bus.
module oe_decoder
  import reg_bus_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   idx,
  output logic [NUM_REGS-1:0] oe
);

  always_comb begin
    oe = '0;
    if (en && (idx != '0)) begin
      oe[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bus_reader.sv
// Sequences one read from a shared tristate register bus: enable, settle, sample, respond.
// Optional WRITE_BYPASS_EN returns a same-cycle snooped write instead of the stale bus value.
//
// state  | meaning
// IDLE   | ready for a request, bus released
// DRIVE  | selected register enabled, bus settling
// SAMPLE | register still enabled, bus captured at end of cycle
// RESP   | response valid, waiting for rd_accept
module reg_bus_reader
  import reg_bus_pkg::*;
(
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_ready,
  output logic [NUM_REGS-1:0] read_oe,
  input  logic [DATA_W-1:0]   bus_in,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                rd_accept,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data
);

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                oe_en;
  logic                capture;
  logic [DATA_W-1:0]   sample_val;

  oe_decoder u_oe_decoder (
    .en  (oe_en),
    .idx (addr_q),
    .oe  (read_oe)
  );

`ifdef WRITE_BYPASS_EN
  logic bypass_hit;

  always_comb begin
    bypass_hit = wr_en && (wr_addr == addr_q) && (addr_q != '0);
    sample_val = bus_in;
    if (addr_q == '0) begin
      sample_val = '0;
    end else if (bypass_hit) begin
      sample_val = wr_data;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};

  // Index 0 has no driver, so whatever floats on the bus is discarded.
  always_comb begin
    sample_val = bus_in;
    if (addr_q == '0) begin
      sample_val = '0;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    rd_ready = 1'b0;
    rd_valid = 1'b0;
    oe_en    = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        rd_ready = 1'b1;
        if (rd_req) begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        oe_en   = 1'b1;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        oe_en   = 1'b1;
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rd_valid = 1'b1;
        if (rd_accept) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && rd_req) begin
        addr_q <= rd_addr;
      end
      if (capture) begin
        rd_data <= sample_val;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_reader.sv
// Self-checking bench for reg_bus_reader: cycle-level transaction model plus directed literal checks.
// Build with +define+WRITE_BYPASS_EN to exercise the write-bypass variant.
module tb_reg_bus_reader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic        rd_ready;
  logic [31:0] read_oe;
  logic [31:0] bus_in;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_accept;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam logic [31:0] BYP_EXP = 32'h2222;
`else
  localparam bit BYP = 1'b0;
  localparam logic [31:0] BYP_EXP = 32'h1111;
`endif

  always #5 clk_sys = ~clk_sys;

  reg_bus_reader dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .read_oe   (read_oe),
    .bus_in    (bus_in),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_accept (rd_accept),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // Register file with tristate drivers: a lone enabled register owns the bus.
  logic [31:0] regs [32];
  logic [31:0] float_val;

  always_comb begin
    bus_in = float_val;
    for (int i = 0; i < 32; i++) begin
      if (read_oe == (32'h1 << i)) bus_in = regs[i];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: age counts edges since the request was taken.
  bit          m_ok  = 1'b0;
  bit          m_out = 1'b0;
  int          m_age = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_last = '0;

  always @(posedge clk_sys) begin
    if (reset) begin
      m_ok   = 1'b1;
      m_out  = 1'b0;
      m_age  = 0;
      m_last = '0;
    end else if (m_out) begin
      if (m_age == 2) begin
        if (m_addr == 0)                                  m_last = '0;
        else if (BYP && wr_en && (wr_addr == m_addr))      m_last = wr_data;
        else                                               m_last = regs[m_addr];
      end
      if (m_age >= 3 && rd_accept) m_out = 1'b0;
      else                         m_age++;
    end else if (rd_req) begin
      m_out  = 1'b1;
      m_age  = 1;
      m_addr = rd_addr;
    end
    if (wr_en) regs[wr_addr] <= wr_data;
  end

  always @(negedge clk_sys) begin
    logic [31:0] exp_oe;
    if (m_ok) begin
      exp_oe = (m_out && (m_age == 1 || m_age == 2) && m_addr != 0) ? (32'h1 << m_addr) : 32'h0;
      chk("rd_ready", {31'b0, rd_ready}, {31'b0, !m_out});
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, (m_out && m_age >= 3)});
      chk("read_oe", read_oe, exp_oe);
      chk("rd_data", rd_data, m_last);
      chk("oe_onehot0", {31'b0, $onehot0(read_oe)}, 32'h1);
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; rd_accept = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; float_val = 32'h0BAD_F00D;

    // Preload the register file through the write port while held in reset.
    for (int i = 0; i < 32; i++) begin
      tick();
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = (i == 7) ? 32'hDEADBEEF : (i == 5) ? 32'h1111 : $urandom;
    end
    tick(); wr_en = 1'b0;
    tick(); reset = 1'b0;
    chk("rst_ready", {31'b0, rd_ready}, 32'h1);
    chk("rst_valid", {31'b0, rd_valid}, 32'h0);
    chk("rst_oe", read_oe, 32'h0);
    chk("rst_data", rd_data, 32'h0);

    // Register 7 read with the address changing after acceptance.
    rd_req = 1'b1; rd_addr = 5'd7;
    tick(); rd_req = 1'b0; rd_addr = 5'd12;
    chk("r7_oe_n1", read_oe, 32'h80);
    tick(); chk("r7_oe_n2", read_oe, 32'h80);
    tick(); chk("r7_valid", {31'b0, rd_valid}, 32'h1);
    chk("r7_data", rd_data, 32'hDEADBEEF);
    rd_accept = 1'b1;
    tick(); rd_accept = 1'b0;

    // Index 0 with a floating all-ones bus.
    float_val = 32'hFFFFFFFF;
    rd_req = 1'b1; rd_addr = 5'd0;
    tick(); rd_req = 1'b0;
    chk("r0_oe_n1", read_oe, 32'h0);
    tick(); chk("r0_oe_n2", read_oe, 32'h0);
    tick(); chk("r0_valid", {31'b0, rd_valid}, 32'h1);
    chk("r0_data", rd_data, 32'h0);
    rd_accept = 1'b1;
    tick(); rd_accept = 1'b0; float_val = $urandom;

    // Response held five cycles while new requests are presented.
    rd_req = 1'b1; rd_addr = 5'd3;
    tick(); rd_req = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold_ready", {31'b0, rd_ready}, 32'h0);
      chk("hold_valid", {31'b0, rd_valid}, 32'h1);
      chk("hold_data", rd_data, regs[3]);
      rd_req  = (k % 2 == 0);
      rd_addr = 5'($urandom);
      tick();
    end
    rd_req = 1'b0; rd_accept = 1'b1;
    tick(); rd_accept = 1'b0;
    chk("hold_no_second", {31'b0, rd_ready}, 32'h1);

    // Reset during SAMPLE aborts the read.
    rd_req = 1'b1; rd_addr = 5'd9;
    tick(); rd_req = 1'b0;
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    chk("abort_oe", read_oe, 32'h0);
    chk("abort_valid", {31'b0, rd_valid}, 32'h0);
    chk("abort_data", rd_data, 32'h0);
    chk("abort_ready", {31'b0, rd_ready}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_resp", {31'b0, rd_valid}, 32'h0);
    end

    // Write to the register being sampled.
    rd_req = 1'b1; rd_addr = 5'd5;
    tick(); rd_req = 1'b0;
    tick(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h2222;
    tick(); wr_en = 1'b0;
    chk("bypass_data", rd_data, BYP_EXP);
    rd_accept = 1'b1;
    tick(); rd_accept = 1'b0;

    // Randomized traffic over all addresses with write noise and rare resets.
    for (int k = 0; k < 3000; k++) begin
      tick();
      reset     = ($urandom_range(0, 199) == 0);
      rd_req    = ($urandom_range(0, 9) < 7);
      rd_addr   = 5'($urandom);
      rd_accept = ($urandom_range(0, 9) < 6);
      wr_en     = ($urandom_range(0, 9) < 3);
      wr_addr   = 5'($urandom);
      wr_data   = $urandom;
      float_val = $urandom;
    end
    tick();
    reset = 1'b0; rd_req = 1'b0; rd_accept = 1'b0; wr_en = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bus_reader.md
REG_BUS_READER -- requirements
Module: reg_bus_reader

Interface
REQ-001 Ports SHALL be: clock; one clock; all logic on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising clock edge.
REQ-003 rd_req  in  1  read request valid; held with rd_addr until accepted.
REQ-004 rd_addr  in  5  register index 0..31.
REQ-005 rd_ready  out  1  high when a request can be accepted; handshake completes on rd_req && rd_ready at a rising edge.
REQ-006 read_oe  out  32  one-hot output-enable to the 32 register tristate drivers; bit i drives register i onto bus_in.
REQ-007 bus_in  in  32  shared tristate read bus.
REQ-008 rd_valid  out  1  response data valid.
REQ-009 rd_data  out  32  response data; stable while rd_valid.
REQ-010 rd_accept  in  1  consumer takes response; completes on rd_valid && rd_accept.
REQ-011 wr_en  in  1, wr_addr  in  5, wr_data  in  32: register-file write port snoop; always present, used only per REQ-026.

Function
REQ-012 FSM states SHALL be IDLE, DRIVE, SAMPLE, RESP.
REQ-013 IDLE: rd_ready=1, read_oe=0; on accepted request latch rd_addr into addr_q, go DRIVE.
REQ-014 DRIVE: read_oe=one-hot(addr_q), rd_ready=0; bus settle cycle; go SAMPLE unconditionally.
REQ-015 SAMPLE: read_oe=one-hot(addr_q); capture bus_in into rd_data at end of cycle; go RESP.
REQ-016 RESP: read_oe=0, rd_valid=1; on rd_accept go IDLE; else hold rd_valid and rd_data unchanged.
REQ-017 Latency: request accepted at edge N; rd_valid high from cycle N+3; minimum request-to-request spacing 4 cycles.
REQ-018 At most one read_oe bit SHALL be high in any cycle; read_oe=0 in IDLE and RESP.
REQ-019 addr_q=0: read_oe stays 0 all states; rd_data captured as 32'h0; same latency as other addresses.
REQ-020 rd_req while not IDLE SHALL be ignored (not accepted, not queued).
REQ-021 rd_addr changes after acceptance SHALL not affect the transaction in progress.
REQ-022 rd_valid SHALL be 0 in IDLE, DRIVE, SAMPLE.

Reset
REQ-023 On reset: state=IDLE, read_oe=0, rd_valid=0, rd_data=0, addr_q=0, rd_ready=1 from first cycle after reset edge.
REQ-024 Reset in any state SHALL abort the transaction; no rd_valid produced for it.
REQ-025 Reset has priority over rd_req and rd_accept in the same cycle.

Configuration
REQ-026 Macro WRITE_BYPASS_EN defined: in SAMPLE, if wr_en && wr_addr==addr_q && addr_q!=0, rd_data SHALL capture wr_data instead of bus_in (new value returned).
REQ-027 WRITE_BYPASS_EN undefined: wr_* ignored; SAMPLE always captures bus_in (pre-write value).

Structure
REQ-028 Package reg_bus_pkg SHALL hold NUM_REGS=32, DATA_W=32, ADDR_W=5 and the FSM state typedef.
REQ-029 Sub-module oe_decoder (5-to-32 one-hot, enable input, all-zero for index 0) SHALL generate read_oe.

Verification
REQ-030 Reset, then rd_req=1, rd_addr=7, register 7 holds 32'hDEADBEEF -> read_oe=32'h80 cycles N+1..N+2, rd_valid cycle N+3, rd_data=32'hDEADBEEF.
REQ-031 rd_addr=0, bus driven 32'hFFFFFFFF by bench -> read_oe stays 0, rd_data=0 at N+3.
REQ-032 rd_accept held low 5 cycles in RESP with new rd_req pulses -> rd_valid/rd_data stable, rd_ready=0, no second transaction.
REQ-033 reset asserted in SAMPLE -> next cycle read_oe=0, rd_valid=0, rd_data=0, rd_ready=1; no response appears.
REQ-034 Read reg 5 (old 32'h1111) with wr_en=1, wr_addr=5, wr_data=32'h2222 during SAMPLE -> rd_data=32'h2222 with WRITE_BYPASS_EN, 32'h1111 without.
REQ-035 Random back-to-back reads over all 32 addresses -> read_oe one-hot or zero every cycle; rd_data matches model.
